// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller: load-use bubbles, ID-resolved branch flushes, dmem wait freeze.
// Latency: all pipeline controls are combinational (Mealy) from state + current inputs.
// Backpressure: dmem_ready_i low during a MEM access freezes the whole pipeline.
// Optional: define HZD_PERF_CNT_EN to add the saturating performance counter outputs.
module hazard_stall_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 256,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       ifid_rs1_i,
    input  logic [4:0]       ifid_rs2_i,
    input  logic             ifid_uses_rs2_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rd_i,
    input  logic             branch_taken_i,
    input  logic             exmem_access_i,
    input  logic             dmem_ready_i,
    output logic             dmem_req_o,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             freeze_o,
    output logic             err_o,
`ifdef HZD_PERF_CNT_EN
    output logic [CNT_W-1:0] lu_stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] mem_wait_cnt_o,
`endif
    output logic [CNT_W-1:0] wait_cnt_o
);

    typedef enum logic {S_RUN, S_WAIT} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_err;

    logic             w_lu_hz;
    logic             w_mem_stall;
    logic             w_freeze;
    logic             w_lu_stall;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_cnt_max;

    // Load in EX whose destination is a source of the instruction in ID (x0 never hazards).
    assign w_lu_hz = idex_memread_i && (idex_rd_i != 5'd0) &&
                     ((idex_rd_i == ifid_rs1_i) ||
                      (ifid_uses_rs2_i && (idex_rd_i == ifid_rs2_i)));

    assign w_mem_stall = exmem_access_i & ~dmem_ready_i;
    assign w_cnt_max   = &r_wait_cnt;
    assign w_cnt_inc   = r_wait_cnt + 1'b1;

    // Freeze whenever the MEM access is not completing this cycle, in either state.
    // An access that vanishes while waiting is treated as released (no freeze).
    always_comb begin
        w_freeze = 1'b0;
        case (r_state)
            S_RUN:   w_freeze = w_mem_stall;
            S_WAIT:  w_freeze = exmem_access_i & ~dmem_ready_i;
            default: w_freeze = 1'b0;
        endcase
    end

    assign w_lu_stall = w_lu_hz & ~w_freeze;

    // Pipeline control outputs with priority freeze > load-use > branch flush.
    always_comb begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        freeze_o      = 1'b0;
        dmem_req_o    = exmem_access_i;
        if (rst_i) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            ifid_flush_o  = 1'b1;
            idex_bubble_o = 1'b1;
            dmem_req_o    = 1'b0;
        end else if (w_freeze) begin
            freeze_o      = 1'b1;
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
        end else if (w_lu_hz) begin
            // A branch seen together with a load-use hazard is re-evaluated next cycle.
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
        end else if (branch_taken_i) begin
            ifid_flush_o  = 1'b1;
        end
    end

    // Wait FSM with saturating wait counter and sticky timeout flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_RUN;
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_mem_stall) begin
                        r_state    <= S_WAIT;
                        r_wait_cnt <= w_cnt_inc;
                    end else begin
                        r_wait_cnt <= '0;
                    end
                end
                S_WAIT: begin
                    if (exmem_access_i && !dmem_ready_i) begin
                        if (!w_cnt_max) begin
                            r_wait_cnt <= w_cnt_inc;
                        end
                    end else begin
                        r_state    <= S_RUN;
                        r_wait_cnt <= '0;
                    end
                end
                default: begin
                    r_state    <= S_RUN;
                    r_wait_cnt <= '0;
                end
            endcase
            // Timeout flags on the edge that brings the counter to TIMEOUT_CYC.
            if (w_mem_stall && !w_cnt_max && (32'(w_cnt_inc) == TIMEOUT_CYC)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign wait_cnt_o = r_wait_cnt;
    assign err_o      = r_err;

`ifdef HZD_PERF_CNT_EN
    logic [CNT_W-1:0] r_lu_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_memw_cnt;

    // Saturating event counters; cleared only by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lu_cnt    <= '0;
            r_flush_cnt <= '0;
            r_memw_cnt  <= '0;
        end else begin
            if (w_lu_stall && !(&r_lu_cnt))       r_lu_cnt    <= r_lu_cnt + 1'b1;
            if (ifid_flush_o && !(&r_flush_cnt))  r_flush_cnt <= r_flush_cnt + 1'b1;
            if (w_freeze && !(&r_memw_cnt))       r_memw_cnt  <= r_memw_cnt + 1'b1;
        end
    end

    assign lu_stall_cnt_o = r_lu_cnt;
    assign flush_cnt_o    = r_flush_cnt;
    assign mem_wait_cnt_o = r_memw_cnt;
`else
    logic w_unused;
    assign w_unused = w_lu_stall;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: vector table for RUN-state hazards, sequences for wait/timeout/reset.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// Uses TIMEOUT_CYC=4 so the timeout path is reachable in a short run.
module tb_hazard_stall_ctrl;

    localparam int unsigned CNT_W = 16;

    logic             clk_i;
    logic             rst_i;
    logic [4:0]       ifid_rs1_i;
    logic [4:0]       ifid_rs2_i;
    logic             ifid_uses_rs2_i;
    logic             idex_memread_i;
    logic [4:0]       idex_rd_i;
    logic             branch_taken_i;
    logic             exmem_access_i;
    logic             dmem_ready_i;
    logic             dmem_req_o;
    logic             pc_write_o;
    logic             ifid_write_o;
    logic             ifid_flush_o;
    logic             idex_bubble_o;
    logic             freeze_o;
    logic             err_o;
    logic [CNT_W-1:0] wait_cnt_o;
`ifdef HZD_PERF_CNT_EN
    logic [CNT_W-1:0] lu_stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;
    logic [CNT_W-1:0] mem_wait_cnt_o;
`endif

    hazard_stall_ctrl #(.TIMEOUT_CYC(4), .CNT_W(CNT_W)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .ifid_rs1_i      (ifid_rs1_i),
        .ifid_rs2_i      (ifid_rs2_i),
        .ifid_uses_rs2_i (ifid_uses_rs2_i),
        .idex_memread_i  (idex_memread_i),
        .idex_rd_i       (idex_rd_i),
        .branch_taken_i  (branch_taken_i),
        .exmem_access_i  (exmem_access_i),
        .dmem_ready_i    (dmem_ready_i),
        .dmem_req_o      (dmem_req_o),
        .pc_write_o      (pc_write_o),
        .ifid_write_o    (ifid_write_o),
        .ifid_flush_o    (ifid_flush_o),
        .idex_bubble_o   (idex_bubble_o),
        .freeze_o        (freeze_o),
        .err_o           (err_o),
`ifdef HZD_PERF_CNT_EN
        .lu_stall_cnt_o  (lu_stall_cnt_o),
        .flush_cnt_o     (flush_cnt_o),
        .mem_wait_cnt_o  (mem_wait_cnt_o),
`endif
        .wait_cnt_o      (wait_cnt_o)
    );

    // {pc_write, ifid_write, ifid_flush, idex_bubble}
    logic [3:0] ctl;
    assign ctl = {pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o};

    typedef struct packed {
        logic       memread;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       uses;
        logic       br;
        logic [3:0] exp_ctl;
    } vec_t;

    vec_t vecs [9];
    int   checks;
    int   errors;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_id(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic uses, input logic br);
        idex_memread_i  = mr;
        idex_rd_i       = rd;
        ifid_rs1_i      = rs1;
        ifid_rs2_i      = rs2;
        ifid_uses_rs2_i = uses;
        branch_taken_i  = br;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        //                mr    rd     rs1    rs2    uses  br    pcw/ifw/flush/bub
        vecs[0] = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 4'b0001}; // load-use on rs1
        vecs[1] = '{1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 4'b1100}; // load gone: resume
        vecs[2] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 4'b1100}; // rd = x0: no hazard
        vecs[3] = '{1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0, 4'b1100}; // rs2 match, rs2 unused
        vecs[4] = '{1'b1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 4'b0001}; // rs2 match, rs2 used
        vecs[5] = '{1'b0, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 4'b1110}; // branch only: flush
        vecs[6] = '{1'b1, 5'd9, 5'd9, 5'd2, 1'b0, 1'b1, 4'b0001}; // branch + load-use
        vecs[7] = '{1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 4'b1100}; // no register match
        vecs[8] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 4'b1100}; // idle

        rst_i = 1'b1;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        exmem_access_i = 1'b1;
        dmem_ready_i   = 1'b0;
        #1;
        chk("rst_ctl", 16'(ctl), 16'(4'b0011));
        chk("rst_frz_req", 16'({freeze_o, dmem_req_o}), 16'd0);
        chk("rst_cnt", wait_cnt_o, 16'd0);
        chk("rst_err", 16'(err_o), 16'd0);

        @(negedge clk_i);
        rst_i = 1'b0;
        exmem_access_i = 1'b0;

        // RUN-state hazard/branch table
        for (int i = 0; i < 9; i++) begin
            @(negedge clk_i);
            set_id(vecs[i].memread, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].uses, vecs[i].br);
            #1;
            chk($sformatf("vec%0d_ctl", i), 16'(ctl), 16'(vecs[i].exp_ctl));
            chk($sformatf("vec%0d_frz", i), 16'(freeze_o), 16'd0);
        end

        // Memory wait of 3 cycles with a load-use + branch held throughout
        @(negedge clk_i);
        set_id(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1);
        exmem_access_i = 1'b1;
        dmem_ready_i   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(negedge clk_i);
                if (k == 3) dmem_ready_i = 1'b1;
            end
            #1;
            chk($sformatf("wait%0d_cnt", k), wait_cnt_o, 16'(k));
            chk($sformatf("wait%0d_frz", k), 16'(freeze_o), 16'((k < 3) ? 1 : 0));
            chk($sformatf("wait%0d_ctl", k), 16'(ctl), 16'((k < 3) ? 4'b0000 : 4'b0001));
            chk($sformatf("wait%0d_req", k), 16'(dmem_req_o), 16'd1);
        end

        // Back-to-back access in the first RUN cycle
        @(negedge clk_i);
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        dmem_ready_i = 1'b0;
        #1;
        chk("b2b_cnt0", wait_cnt_o, 16'd0);
        chk("b2b_frz0", 16'(freeze_o), 16'd1);
        @(negedge clk_i);
        dmem_ready_i = 1'b1;
        #1;
        chk("b2b_cnt1", wait_cnt_o, 16'd1);
        chk("b2b_frz1", 16'(freeze_o), 16'd0);
        @(negedge clk_i);
        exmem_access_i = 1'b0;
        dmem_ready_i   = 1'b0;
        #1;
        chk("b2b_cnt_clr", wait_cnt_o, 16'd0);

        // Timeout at TIMEOUT_CYC=4, sticky after ready
        @(negedge clk_i);
        exmem_access_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk_i);
            #1;
            chk($sformatf("to%0d_cnt", k), wait_cnt_o, 16'(k));
            chk($sformatf("to%0d_err", k), 16'(err_o), 16'((k >= 4) ? 1 : 0));
            chk($sformatf("to%0d_frz", k), 16'(freeze_o), 16'd1);
        end
        @(negedge clk_i);
        dmem_ready_i = 1'b1;
        #1;
        chk("to_ready_frz", 16'(freeze_o), 16'd0);
        chk("to_ready_err", 16'(err_o), 16'd1);
        @(negedge clk_i);
        exmem_access_i = 1'b0;
        dmem_ready_i   = 1'b0;
        #1;
        chk("to_after_cnt", wait_cnt_o, 16'd0);
        chk("to_after_err", 16'(err_o), 16'd1);

        // Access dropping while waiting releases the freeze
        @(negedge clk_i);
        exmem_access_i = 1'b1;
        #1;
        chk("drop_enter_frz", 16'(freeze_o), 16'd1);
        @(negedge clk_i);
        exmem_access_i = 1'b0;
        #1;
        chk("drop_frz", 16'(freeze_o), 16'd0);
        chk("drop_req", 16'(dmem_req_o), 16'd0);
        chk("drop_cnt", wait_cnt_o, 16'd1);
        chk("drop_ctl", 16'(ctl), 16'(4'b1100));
        @(negedge clk_i);
        #1;
        chk("drop_cnt_clr", wait_cnt_o, 16'd0);

        // Asynchronous reset mid-WAIT
        @(negedge clk_i);
        exmem_access_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        chk("mid_cnt", wait_cnt_o, 16'd2);
        #2;
        rst_i = 1'b1;
        #1;
        chk("arst_cnt", wait_cnt_o, 16'd0);
        chk("arst_err", 16'(err_o), 16'd0);
        chk("arst_ctl", 16'(ctl), 16'(4'b0011));
        chk("arst_frz_req", 16'({freeze_o, dmem_req_o}), 16'd0);
`ifdef HZD_PERF_CNT_EN
        chk("arst_lu_pc", lu_stall_cnt_o, 16'd0);
        chk("arst_fl_pc", flush_cnt_o, 16'd0);
        chk("arst_mw_pc", mem_wait_cnt_o, 16'd0);
`endif
        @(negedge clk_i);
        rst_i          = 1'b0;
        exmem_access_i = 1'b0;
        #1;
        chk("post_rst_ctl", 16'(ctl), 16'(4'b1100));
        chk("post_rst_cnt", wait_cnt_o, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
